// File: rtl/adc_seq_pkg.sv
// Shared widths and FSM state type for the ADC scan sequencer.
package adc_seq_pkg;
    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUBLISH,
        S_DONE
    } seq_state_t;
endpackage

// File: rtl/adc_seq_accum.sv
// Per-channel sample accumulator, sample counter and power-of-two average.
module adc_seq_accum
    import adc_seq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  i_clr,
    input  logic                  i_add,
    input  logic [ADC_DATA_W-1:0] i_data,
    output logic                  o_last,
    output logic [ADC_DATA_W-1:0] o_avg
);
    localparam int ACC_W = ADC_DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_data);
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // o_last flags that the sample being added now completes the set
    assign o_last = (r_cnt == LAST_CNT);
    assign o_avg  = r_acc[AVG_LOG2 +: ADC_DATA_W];
endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans a channel range through an Avalon-ST ADC control core and publishes
// averaged results, with response timeout and channel-mismatch detection.
//   state     | meaning
//   S_IDLE    | scan stopped, waiting for enable
//   S_ISSUE   | command presented, waiting for cmd_ready
//   S_WAIT    | one command outstanding, waiting for matching response
//   S_PUBLISH | averaged result presented for one cycle
//   S_DONE    | scan_done presented for one cycle after the last channel
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_FIRST = 1,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  enable,
    input  logic                  clear_err,
    output logic                  cmd_valid,
    output logic [ADC_CH_W-1:0]   cmd_channel,
    output logic                  cmd_sop,
    output logic                  cmd_eop,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    input  logic [ADC_CH_W-1:0]   rsp_channel,
    input  logic [ADC_DATA_W-1:0] rsp_data,
    output logic                  result_valid,
    output logic [ADC_CH_W-1:0]   result_channel,
    output logic [ADC_DATA_W-1:0] result_data,
    output logic                  scan_done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  chan_err
);
    localparam logic [ADC_CH_W-1:0] CH_FIRST_C = ADC_CH_W'(CH_FIRST);
    localparam logic [ADC_CH_W-1:0] CH_LAST_C  = ADC_CH_W'(CH_FIRST + NUM_CH - 1);
    localparam int                  TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]    TMR_LOAD   = TMR_W'(TIMEOUT - 1);

    seq_state_t            r_state;
    logic [ADC_CH_W-1:0]   r_ch;
    logic [TMR_W-1:0]      r_tmr;
    logic                  r_cmd_valid;
    logic                  r_result_valid;
    logic                  r_scan_done;
    logic                  r_timeout_err;
    logic                  r_chan_err;

    logic                  w_match;
    logic                  w_mismatch;
    logic                  w_timeout;
    logic                  w_last_smp;
    logic                  w_last_ch;
    logic                  w_acc_clr;
    logic [ADC_DATA_W-1:0] w_avg;

    assign w_match    = (r_state == S_WAIT) && rsp_valid && (rsp_channel == r_ch);
    assign w_mismatch = (r_state == S_WAIT) && rsp_valid && (rsp_channel != r_ch);
    // A response landing on the terminal-count cycle still counts
    assign w_timeout  = (r_state == S_WAIT) && !w_match && (r_tmr == '0);
    assign w_last_ch  = (r_ch == CH_LAST_C);
    assign w_acc_clr  = (r_state == S_IDLE) || (r_state == S_PUBLISH) ||
                        (r_state == S_DONE) || w_timeout;

    adc_seq_accum #(
        .AVG_LOG2(AVG_LOG2)
    ) u_accum (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .i_clr        (w_acc_clr),
        .i_add        (w_match),
        .i_data       (rsp_data),
        .o_last       (w_last_smp),
        .o_avg        (w_avg)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state        <= S_IDLE;
            r_ch           <= CH_FIRST_C;
            r_tmr          <= '0;
            r_cmd_valid    <= 1'b0;
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_chan_err     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;

            if (w_timeout)      r_timeout_err <= 1'b1;
            else if (clear_err) r_timeout_err <= 1'b0;
            if (w_mismatch)     r_chan_err    <= 1'b1;
            else if (clear_err) r_chan_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state     <= S_ISSUE;
                        r_ch        <= CH_FIRST_C;
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= S_WAIT;
                        r_cmd_valid <= 1'b0;
                        r_tmr       <= TMR_LOAD;
                    end
                end
                S_WAIT: begin
                    if (w_match) begin
                        if (w_last_smp) begin
                            r_state        <= S_PUBLISH;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_cmd_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        if (!enable) begin
                            r_state <= S_IDLE;
                        end else if (w_last_ch) begin
                            r_state     <= S_DONE;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_ch        <= r_ch + ADC_CH_W'(1);
                            r_cmd_valid <= 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_PUBLISH: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_last_ch) begin
                        r_state     <= S_DONE;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_state     <= S_ISSUE;
                        r_ch        <= r_ch + ADC_CH_W'(1);
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (enable) begin
                        r_state     <= S_ISSUE;
                        r_ch        <= CH_FIRST_C;
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid      = r_cmd_valid;
    assign cmd_sop        = r_cmd_valid;
    assign cmd_eop        = r_cmd_valid;
    assign cmd_channel    = r_cmd_valid ? r_ch : '0;
    assign result_valid   = r_result_valid;
    assign result_channel = r_result_valid ? r_ch : '0;
    assign result_data    = r_result_valid ? w_avg : '0;
    assign scan_done      = r_scan_done;
    assign busy           = (r_state != S_IDLE);
    assign timeout_err    = r_timeout_err;
    assign chan_err       = r_chan_err;
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of channels scanned per pass, range 1..16.
REQ-002 Parameter CH_FIRST, default 1: first channel number; scan covers CH_FIRST..CH_FIRST+NUM_CH-1, max 31.
REQ-003 Parameter AVG_LOG2, default 2: 2^AVG_LOG2 conversions averaged per channel, range 0..4.
REQ-004 Parameter TIMEOUT, default 1023: max cycles from command acceptance to matching response.
REQ-005 clk_clk  in  1  single clock for all logic.
REQ-006 reset_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 enable  in  1  level; high = scan continuously.
REQ-008 clear_err  in  1  pulse; clears sticky error flags.
REQ-009 cmd_valid / cmd_channel / cmd_sop / cmd_eop  out  1/5/1/1  Avalon-ST command to ADC control core.
REQ-010 cmd_ready  in  1  command accepted when cmd_valid and cmd_ready both high.
REQ-011 rsp_valid / rsp_channel / rsp_data  in  1/5/12  Avalon-ST response from ADC control core.
REQ-012 result_valid / result_channel / result_data  out  1/5/12  one-cycle pulse with averaged sample.
REQ-013 scan_done  out  1  one-cycle pulse after last channel of a pass is published.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 timeout_err / chan_err  out  1/1  sticky error flags.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, PUBLISH, DONE.
REQ-017 IDLE -> ISSUE when enable=1; channel index := CH_FIRST, accumulator := 0, sample count := 0.
REQ-018 ISSUE: cmd_valid=1, cmd_sop=cmd_eop=1, cmd_channel=current channel; all held stable until cmd_ready=1, then -> WAIT next cycle.
REQ-019 At most one command outstanding; cmd_valid=0 in every state except ISSUE.
REQ-020 WAIT: rsp_valid=1 with rsp_channel equal to current channel adds zero-extended rsp_data to a (12+AVG_LOG2)-bit accumulator and increments sample count.
REQ-021 WAIT: rsp_valid=1 with mismatched rsp_channel is discarded, sets chan_err, keeps waiting; rsp_valid outside WAIT is ignored.
REQ-022 After a matching response: count < 2^AVG_LOG2 -> ISSUE; count = 2^AVG_LOG2 -> PUBLISH.
REQ-023 PUBLISH (one cycle): result_valid=1, result_channel=current channel, result_data=accumulator >> AVG_LOG2 (truncation, no rounding); latency = 1 cycle after last matching response sampled.
REQ-024 Timeout counter restarts on command acceptance; reaching TIMEOUT in WAIT sets timeout_err, abandons channel (no result_valid), advances as if PUBLISH completed.
REQ-025 After PUBLISH or abandon: if not last channel, increment channel, clear accumulator and count, -> ISSUE (if enable=1).
REQ-026 After last channel: -> DONE, scan_done=1 one cycle; then -> ISSUE at CH_FIRST if enable=1, else IDLE.
REQ-027 enable falling mid-channel: current channel completes (all samples, publish or timeout), then -> IDLE without scan_done.
REQ-028 clear_err and a new error event in the same cycle: flag is set (set wins).
REQ-029 result_valid and scan_done never assert in the same cycle.

Reset
REQ-030 Reset asserted: state IDLE, channel index CH_FIRST, accumulator, counters, and all outputs 0, immediately and independently of clk_clk.
REQ-031 Reset mid-transaction drops the outstanding command; a late response after release is ignored (IDLE).

Structure
REQ-032 Package adc_seq_pkg holds the state enum, ADC_DATA_W=12, ADC_CH_W=5.
REQ-033 Sub-module adc_seq_accum implements accumulator, sample counter and shift-average.

Verification
REQ-034 NUM_CH=2, AVG_LOG2=2, model returns 100,101,102,104 on ch1 -> result_valid ch1 data 101, then ch2 processed, scan_done after ch2 result.
REQ-035 cmd_ready held low 5 cycles -> cmd_valid and cmd_channel stable 6 cycles, exactly one command accepted.
REQ-036 ch2 never answered, TIMEOUT=20 -> timeout_err at cycle 20 after acceptance, no ch2 result, scan continues at ch3.
REQ-037 Response with rsp_channel=7 while waiting on ch1 -> chan_err=1, sample discarded, ch1 average unchanged; clear_err pulse -> chan_err=0.
REQ-038 enable dropped during ch1 sample 2 of 4 -> ch1 result published, no scan_done, busy=0 next cycle after publish.
REQ-039 reset_reset_n low during WAIT -> all outputs 0 asynchronously, state IDLE, subsequent rsp_valid ignored.
